// File: rtl/store_rmw_unit.sv
// Store path for sw/sh/sb. Word stores write straight through. Halfword and byte
// stores read the aligned word, merge the new lane(s), then write the word back.
module store_rmw_unit #(
  parameter int MEM_READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign
);

  localparam int CW = $clog2(MEM_READ_LATENCY + 1) + 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_READ_LATENCY);

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
  } req_t;

  state_t        state, state_n;
  req_t          req_q;
  logic [31:0]   merge_q;
  logic [CW-1:0] cnt_q;
  logic          misaligned;
  logic [3:0]    be;
  logic [31:0]   lane_data;
  logic [31:0]   merged;

  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'b00:   misaligned = (addr[1:0] != 2'b00);
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = 1'b1;
    endcase
  end

  // Byte enables select which lanes of the read word get replaced.
  always_comb begin
    be        = 4'b0000;
    lane_data = {2{req_q.data[15:0]}};
    case (req_q.size)
      2'b01: be = req_q.addr[1] ? 4'b1100 : 4'b0011;
      2'b10: begin
        be        = 4'b0001 << req_q.addr[1:0];
        lane_data = {4{req_q.data[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign merged[8*k +: 8] = be[k] ? lane_data[8*k +: 8] : mem_rdata[8*k +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      req_q   <= '0;
      merge_q <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        req_q   <= '{addr: addr, size: size, data: wdata};
        merge_q <= wdata;
        cnt_q   <= '0;
      end
      if (state == READ) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST) merge_q <= merged;
      end
    end
  end

  always_comb begin
    state_n   = state;
    mem_addr  = '0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    busy      = 1'b1;
    done      = 1'b0;
    misalign  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (misaligned)         state_n = ERR;
          else if (size == 2'b00) state_n = WRITE;
          else                    state_n = READ;
        end
      end
      READ: begin
        mem_addr = {req_q.addr[31:2], 2'b00};
        if (cnt_q == LAST) state_n = WRITE;
      end
      WRITE: begin
        mem_addr  = {req_q.addr[31:2], 2'b00};
        mem_wr    = 1'b1;
        mem_wdata = merge_q;
        state_n   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      ERR: begin
        done     = 1'b1;
        misalign = 1'b1;
        state_n  = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule
